// File: rtl/dds_sine_gen.sv
// dds_sine_gen: direct digital synthesiser with a phase accumulator, glitch-free tuning-word
// updates, phase offset, quarter-wave sine LUT and amplitude scaling. The output is unsigned
// offset-binary.
// Optional: define DDS_COS_OUT_EN to add a quadrature output data_cos.
module dds_sine_gen #(
  parameter int unsigned        PHASE_W = 32,
  parameter int unsigned        ADDR_W  = 10,
  parameter int unsigned        DATA_W  = 10,
  parameter int unsigned        AMP_W   = 8,
  parameter logic [PHASE_W-1:0] TW_INIT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tw_load,
  input  logic [PHASE_W-1:0] tw_in,
  output logic               tw_busy,
  input  logic [ADDR_W-1:0]  phase_off,
  input  logic [AMP_W:0]     amp,
  output logic [ADDR_W-1:0]  phase,
  output logic [DATA_W-1:0]  data_sin,
`ifdef DDS_COS_OUT_EN
  output logic [DATA_W-1:0]  data_cos,
`endif
  output logic               out_valid,
  output logic               wrap
);

  localparam int unsigned      LutN     = 2 ** (ADDR_W - 2);
  localparam int unsigned      MagW     = DATA_W - 1;
  localparam logic [DATA_W-1:0] MidLo   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MidHi   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] One     = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [AMP_W:0]    AmpUnity = {1'b1, {AMP_W{1'b0}}};

  // Half-sample offset keeps the four quadrants exactly symmetric about midscale - 0.5.
  function automatic logic [MagW-1:0] lut_val(input int i);
    real m;
    real x;
    m = real'(2 ** (DATA_W - 1) - 1);
    x = m * $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(LutN));
    return MagW'($rtoi(x + 0.5));
  endfunction

  // Scale a magnitude by the amplitude and fold it onto the positive or negative half-wave.
  function automatic logic [DATA_W-1:0] shape(input logic [MagW-1:0] mag, input logic neg,
                                              input logic [AMP_W:0] a);
    logic [DATA_W+AMP_W-1:0] prod;
    logic [DATA_W-1:0]       ms;
    prod = {{(AMP_W+1){1'b0}}, mag} * {{MagW{1'b0}}, a};
    ms   = DATA_W'(prod >> AMP_W);
    return neg ? (MidLo - ms) : (MidLo + One + ms);
  endfunction

  logic [MagW-1:0] lut [LutN];
  for (genvar g = 0; g < LutN; g++) begin : g_lut
    localparam logic [MagW-1:0] Val = lut_val(g);
    assign lut[g] = Val;
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W:0]   acc_sum;
  logic               carry, carry_q;
  logic [PHASE_W-1:0] tw_active_q, tw_active_d, tw_pending_q, tw_pending_d;
  logic               tw_busy_q, tw_busy_d, tw_apply;

  logic [ADDR_W-1:0]  addr, phase_q;
  logic [1:0]         quad;
  logic [ADDR_W-3:0]  idx, lut_idx;
  logic [MagW-1:0]    mag_q;
  logic               neg_q;
  logic [AMP_W:0]     amp_sat;
  logic [DATA_W-1:0]  data_d, data_q;
  logic [1:0]         vld_q, wrp_q;
  logic               vld_out_q, wrp_out_q;

  // Accumulator advance and deferred tuning-word handshake; a zero word never wraps, so the
  // pending word is applied immediately in that case.
  always_comb begin
    acc_sum      = {1'b0, acc_q} + {1'b0, tw_active_q};
    carry        = en & acc_sum[PHASE_W];
    acc_d        = en ? acc_sum[PHASE_W-1:0] : acc_q;
    tw_apply     = tw_busy_q & ((tw_active_q == '0) | carry);
    tw_active_d  = tw_apply ? tw_pending_q : tw_active_q;
    tw_pending_d = tw_load ? tw_in : tw_pending_q;
    tw_busy_d    = tw_load | (tw_busy_q & ~tw_apply);
  end

  // Accumulator stage registers; carry_q travels with the accumulator value it produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      carry_q      <= 1'b0;
      tw_active_q  <= TW_INIT;
      tw_pending_q <= '0;
      tw_busy_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      carry_q      <= carry;
      tw_active_q  <= tw_active_d;
      tw_pending_q <= tw_pending_d;
      tw_busy_q    <= tw_busy_d;
    end
  end

  // Address, quarter-wave fold and output shaping for the three pipeline stages.
  always_comb begin
    addr    = acc_q[PHASE_W-1 -: ADDR_W] + phase_off;
    quad    = phase_q[ADDR_W-1 -: 2];
    idx     = phase_q[ADDR_W-3:0];
    lut_idx = quad[0] ? ~idx : idx;
    amp_sat = (amp > AmpUnity) ? AmpUnity : amp;
    data_d  = shape(mag_q, neg_q, amp_sat);
  end

  // Free-running sample pipeline with valid and wrap flags delayed alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      data_q    <= MidHi;
      vld_q     <= '0;
      vld_out_q <= 1'b0;
      wrp_q     <= '0;
      wrp_out_q <= 1'b0;
    end else begin
      phase_q   <= addr;
      mag_q     <= lut[lut_idx];
      neg_q     <= quad[1];
      data_q    <= data_d;
      vld_q     <= {vld_q[0], en};
      vld_out_q <= vld_q[1];
      wrp_q     <= {wrp_q[0], carry_q};
      wrp_out_q <= wrp_q[1];
    end
  end

`ifdef DDS_COS_OUT_EN
  logic [1:0]        quad_c;
  logic [ADDR_W-3:0] lut_idx_c;
  logic [MagW-1:0]   mag_c_q;
  logic              neg_c_q;
  logic [DATA_W-1:0] data_c_q;

  // Cosine reads the same table one quadrant ahead.
  always_comb begin
    quad_c    = quad + 2'd1;
    lut_idx_c = quad_c[0] ? ~idx : idx;
  end

  // Cosine magnitude and output stages, matched in latency to the sine path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_c_q  <= '0;
      neg_c_q  <= 1'b0;
      data_c_q <= MidHi;
    end else begin
      mag_c_q  <= lut[lut_idx_c];
      neg_c_q  <= quad_c[1];
      data_c_q <= shape(mag_c_q, neg_c_q, amp_sat);
    end
  end

  assign data_cos = data_c_q;
`endif

  assign tw_busy   = tw_busy_q;
  assign phase     = phase_q;
  assign data_sin  = data_q;
  assign out_valid = vld_out_q;
  assign wrap      = wrp_out_q;

endmodule

// File: tb/tb_dds_sine_gen.sv
// tb_dds_sine_gen: directed bench for dds_sine_gen at default parameters (M = 511).
module tb_dds_sine_gen;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        en        = 1'b0;
  logic        tw_load   = 1'b0;
  logic [31:0] tw_in     = '0;
  logic        tw_busy;
  logic [9:0]  phase_off = '0;
  logic [8:0]  amp       = 9'd256;
  logic [9:0]  phase;
  logic [9:0]  data_sin;
  logic        out_valid;
  logic        wrap;
`ifdef DDS_COS_OUT_EN
  logic [9:0]  data_cos;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int off;
    int amp;
    int ph;
    int sn;
    int cs;
  } vec_t;

  vec_t vecs [13];

  dds_sine_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tw_load   (tw_load),
    .tw_in     (tw_in),
    .tw_busy   (tw_busy),
    .phase_off (phase_off),
    .amp       (amp),
    .phase     (phase),
    .data_sin  (data_sin),
`ifdef DDS_COS_OUT_EN
    .data_cos  (data_cos),
`endif
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_phase(input int target, input int budget);
    int n = 0;
    while (int'(phase) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_phase", int'(phase), target);
  endtask

  task automatic wait_apply(input int exp_ph, input int budget);
    int n = 0;
    while (tw_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("apply_busy", int'(tw_busy), 0);
    check("apply_phase", int'(phase), exp_ph);
  endtask

  task automatic load_tw(input logic [31:0] w);
    tw_in   = w;
    tw_load = 1'b1;
    @(negedge clk);
    tw_load = 1'b0;
  endtask

  function automatic int exp_sin(input int a);
    case (a)
      0:        return 514;
      255, 256: return 1023;
      512:      return 509;
      768:      return 0;
      default:  return -1;
    endcase
  endfunction

  initial begin
    int m;
    int a;
    int seq1 [4];
    int seq2 [6];
    seq1 = '{0, 2, 4, 6};
    seq2 = '{0, 0, 1, 1, 2, 2};

    // phase_off, amp, phase, sine, cosine with acc stalled at 0
    vecs[0]  = '{0,   256, 0,   514,  1023};
    vecs[1]  = '{255, 256, 255, 1023, 514};
    vecs[2]  = '{256, 256, 256, 1023, 509};
    vecs[3]  = '{512, 256, 512, 509,  0};
    vecs[4]  = '{768, 256, 768, 0,    514};
    vecs[5]  = '{256, 128, 256, 767,  510};
    vecs[6]  = '{768, 128, 768, 256,  513};
    vecs[7]  = '{256, 511, 256, 1023, 509};
    vecs[8]  = '{768, 511, 768, 0,    514};
    vecs[9]  = '{0,   0,   0,   512,  512};
    vecs[10] = '{512, 0,   512, 511,  511};
    vecs[11] = '{128, 256, 128, 874,  872};
    vecs[12] = '{896, 256, 896, 151,  874};

    // Asynchronous reset before any clock edge
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_data", int'(data_sin), 512);
    check("rst_valid", int'(out_valid), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_busy", int'(tw_busy), 0);
`ifdef DDS_COS_OUT_EN
    check("rst_cos", int'(data_cos), 512);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rel_data", int'(data_sin), 514);
    check("rel_phase", int'(phase), 0);
    check("rel_valid", int'(out_valid), 1);
    repeat (3) @(negedge clk);
    check("rel_phase_hold", int'(phase), 0);

    // Static address map via phase offset and amplitude
    for (int i = 0; i < 13; i++) begin
      phase_off = 10'(vecs[i].off);
      amp       = 9'(vecs[i].amp);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_phase", i), int'(phase), vecs[i].ph);
      check($sformatf("vec%0d_sin", i), int'(data_sin), vecs[i].sn);
`ifdef DDS_COS_OUT_EN
      check($sformatf("vec%0d_cos", i), int'(data_cos), vecs[i].cs);
`endif
    end
    phase_off = '0;
    amp       = 9'd256;
    repeat (4) @(negedge clk);

    // Load while stalled: applied on the next edge
    load_tw(32'h0040_0000);
    check("load0_busy_hi", int'(tw_busy), 1);
    @(negedge clk);
    check("load0_busy_lo", int'(tw_busy), 0);

    // Sweep one full cycle plus margin at +1 address per sample
    wait_phase(5, 20);
    m = 5;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      m = (m + 1) % 1024;
      a = (m + 1022) % 1024;
      check("sweep_phase", int'(phase), m);
      if (exp_sin(a) >= 0) check($sformatf("sweep_sin_a%0d", a), int'(data_sin), exp_sin(a));
      check("sweep_wrap", int'(wrap), (a == 0) ? 1 : 0);
    end

    // en 1-0-1: freeze, valid delay, no skipped addresses
    en = 1'b0;
    @(negedge clk);
    check("en_s1_phase", int'(phase), (m + 1) % 1024);
    check("en_s1_valid", int'(out_valid), 1);
    @(negedge clk);
    check("en_s2_valid", int'(out_valid), 1);
    @(negedge clk);
    check("en_s3_valid", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    check("en_s5_phase", int'(phase), (m + 1) % 1024);
    en = 1'b1;
    @(negedge clk);
    check("en_s6_phase", int'(phase), (m + 1) % 1024);
    check("en_s6_valid", int'(out_valid), 0);
    @(negedge clk);
    check("en_s7_phase", int'(phase), (m + 2) % 1024);
    check("en_s7_valid", int'(out_valid), 0);
    @(negedge clk);
    check("en_s8_phase", int'(phase), (m + 3) % 1024);
    check("en_s8_valid", int'(out_valid), 1);

    // Deferred update to 2^23 loaded mid-cycle
    wait_phase(300, 1100);
    load_tw(32'h0080_0000);
    check("load1_busy", int'(tw_busy), 1);
    wait_apply(1023, 2100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("step2_phase%0d", i), int'(phase), seq1[i]);
    end

    // Two loads before the wrap: the last one wins
    wait_phase(300, 600);
    load_tw(32'h0040_0000);
    check("load2_busy", int'(tw_busy), 1);
    wait_phase(600, 300);
    load_tw(32'h0020_0000);
    check("load3_busy", int'(tw_busy), 1);
    wait_apply(1022, 600);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("half_phase%0d", i), int'(phase), seq2[i]);
    end

    // Reset mid-run with a pending word outstanding
    load_tw(32'h0080_0000);
    check("load4_busy", int'(tw_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_phase", int'(phase), 0);
    check("mid_rst_data", int'(data_sin), 512);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_wrap", int'(wrap), 0);
    check("mid_rst_busy", int'(tw_busy), 0);
`ifdef DDS_COS_OUT_EN
    check("mid_rst_cos", int'(data_cos), 512);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_phase", int'(phase), 0);
    check("post_rst_busy", int'(tw_busy), 0);
    check("post_rst_data", int'(data_sin), 514);
    check("post_rst_valid", int'(out_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_sine_gen.md
Name: dds_sine_gen

Overview:
- Parametrised successor to the fixed 10-bit sine generator: a direct digital synthesiser with a PHASE_W phase accumulator, a runtime tuning word, a phase offset, a quarter-wave LUT and amplitude scaling.
- A clock-enable input replaces the external clock divider. Output stays unsigned offset-binary for the DAC path.
- Tuning-word changes are deferred to the next phase wrap, so frequency changes are glitch-free.

Parameters:
PHASE_W, 32, accumulator width
ADDR_W, 10, phase bits used for the LUT and the phase output (>=4)
DATA_W, 10, sample width, offset-binary
AMP_W, 8, amplitude fraction bits; unity = 2^AMP_W
TW_INIT, 0, tuning word loaded at reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  sample enable; accumulator advances only when high
tw_load  in  1  one-cycle strobe; capture tw_in as the pending tuning word
tw_in  in  PHASE_W  new tuning word
tw_busy  out  1  pending word not yet applied
phase_off  in  ADDR_W  phase offset added to the truncated phase
amp  in  AMP_W+1  amplitude; values > 2^AMP_W saturate to 2^AMP_W
phase  out  ADDR_W  registered LUT address (acc MSBs + phase_off, mod 2^ADDR_W)
data_sin  out  DATA_W  sine sample, midscale 2^(DATA_W-1)
out_valid  out  1  data_sin holds a new sample
wrap  out  1  one-cycle pulse, accumulator carry-out, aligned with data_sin

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous assert and synchronous deassert (synchroniser external).
- Reset values: acc=0, tw_active=TW_INIT, pending=0, tw_busy=0, phase=0, data_sin=2^(DATA_W-1), out_valid=0, wrap=0. All pipeline registers are cleared.
- Accumulator:
  - If en, acc <= acc + tw_active, modulo 2^PHASE_W, and carry is the carry-out. Otherwise acc holds and carry=0.
- Tuning-word handshake:
  - tw_load captures tw_in into pending and sets tw_busy on the next edge.
  - tw_load while tw_busy overwrites pending. The last word wins.
  - Pending is applied (tw_active <= pending, tw_busy <= 0) on the edge where en && carry. The new word is used from the following accumulation.
  - If tw_active==0, pending is applied on the edge after tw_load, because a stalled accumulator never wraps.
  - If tw_load coincides with an apply edge, the newly loaded word becomes pending and tw_busy stays 1.
- Pipeline: 3 stages, free-running every clk. data_sin at edge n+3 reflects the acc value present at edge n.
  - S1: addr = acc[PHASE_W-1 -: ADDR_W] + phase_off, registered and driven on phase. Quadrant q = addr[ADDR_W-1:ADDR_W-2], idx = addr[ADDR_W-3:0].
  - S2: idx' = idx when q[0]==0, otherwise ~idx. mag = LUT[idx'], registered, with q delayed alongside.
  - S3: ms = (mag * amp_sat) >> AMP_W. data_sin = M+1+ms when q[1]==0, otherwise M-ms, where M = 2^(DATA_W-1)-1.
- LUT: 2^(ADDR_W-2) entries of DATA_W-1 bits. LUT[i] = round(M*sin(pi/2*(i+0.5)/2^(ADDR_W-2))). The half-sample offset makes the mirrored and negated halves exactly symmetric about 2^(DATA_W-1)-0.5.
- out_valid = en delayed 3 cycles. wrap = carry delayed 3 cycles.
- phase_off and amp are sampled in S1 and S3 respectively, with no handshake. A change takes effect on the next sample.
- Reset mid-operation returns everything to the reset values immediately, including discarding any pending word.

Optional Feature:
- Macro: DDS_COS_OUT_EN.
- When defined:
  - Adds output data_cos (DATA_W), which is the same pipeline with the quadrant incremented by 1 (addr + 2^(ADDR_W-2)) using a second LUT read.
  - data_cos has identical latency and scaling to data_sin.
  - Reset value of data_cos is 2^(DATA_W-1).
- When undefined: the port and its logic are absent. data_sin behaviour is unchanged.

Test Plan (defaults, M=511):
- Reset with TW_INIT=0, rst_n low:
  - Outputs are 0/512/0/0 during reset.
  - After release with en=1 and acc stalled, data_sin=514 (LUT[0]=2) and phase=0 constant.
- tw_load of 2^22 while tw_active=0, then en=1 continuously:
  - tw_busy high for exactly 1 cycle.
  - phase steps +1 per cycle.
  - data_sin is 514 at addr 0, 1023 at addr 255 and 256, 509 at addr 512, 0 at addr 768.
  - wrap pulses every 1024 cycles, coincident with the addr-0 sample.
- With tw=2^22 running, tw_load of 2^23 at addr 300:
  - tw_busy stays high until the wrap edge.
  - phase then steps +2 from the following sample.
  - A second load of 2^21 before the wrap results in a +0.5 step (one address every 2 cycles) after the wrap.
- amp=128, then amp=511:
  - amp=128 gives peak 767 and trough 256.
  - amp=511 saturates, giving peak 1023 and trough 0.
- en toggled 1-0-1:
  - phase freezes while en=0.
  - out_valid falls 3 cycles after en falls and rises 3 cycles after en rises.
  - No samples are skipped.
- Set phase_off=256 with acc=0:
  - phase=256 and data_sin=1023.
  - With DDS_COS_OUT_EN and phase_off=0, data_cos=1023 when data_sin=514.
  - Assert rst_n low mid-run: all outputs return to reset values asynchronously and tw_busy clears.
